// File: rtl/path_request_feeder.sv
// Request FIFO feeding (start, end) node pairs to the CPU over its data bus.
// The CPU claims the head, reads START/END, computes a path, then writes DONE.
module path_request_feeder #(
  parameter int unsigned NODE_W     = 5,
  parameter int unsigned DEPTH      = 2,
  parameter logic [31:0] ADR_START  = 32'h0200_0000,
  parameter logic [31:0] ADR_END    = 32'h0200_0004,
  parameter logic [31:0] ADR_DONE   = 32'h0200_000C,
  parameter logic [31:0] ADR_STATUS = 32'h0200_0010,
  parameter logic [31:0] ADR_CLAIM  = 32'h0200_0014
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [NODE_W-1:0] req_start,
  input  logic [NODE_W-1:0] req_end,
  input  logic              MemWrite,
  input  logic [31:0]       DataAdr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              rd_hit,
  output logic              busy,
  output logic              done_pulse
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = 2 * NODE_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e            state_q;
  logic [ENT_W-1:0]  fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [NODE_W-1:0] active_start_q;
  logic [NODE_W-1:0] active_end_q;
  logic              done_pulse_q;

  logic              full;
  logic              not_empty;
  logic              hit_start, hit_end, hit_status;
  logic              claim_wr, done_wr;
  logic              push, claim, done;
  logic [31:0]       status_word;

  // Handshake: a request transfers on the falling edge where req_valid and
  // req_ready are both high; the requester holds its fields until then.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign not_empty = (count_q != '0);
  assign req_ready = !full;
  assign push      = req_valid && req_ready;

  assign hit_start  = (DataAdr == ADR_START);
  assign hit_end    = (DataAdr == ADR_END);
  assign hit_status = (DataAdr == ADR_STATUS);

  assign claim_wr = MemWrite && (DataAdr == ADR_CLAIM) && (WriteData == 32'd1);
  assign done_wr  = MemWrite && (DataAdr == ADR_DONE)  && (WriteData == 32'd1);

  // Claim looks at the pre-edge count, so a push landing on the same edge
  // into an empty FIFO cannot be claimed until the following edge.
  assign claim = claim_wr && not_empty && (state_q == ST_IDLE);
  assign done  = done_wr && (state_q == ST_BUSY);

  assign busy       = (state_q == ST_BUSY);
  assign done_pulse = done_pulse_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (claim) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, claim})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      active_start_q <= '0;
      active_end_q   <= '0;
      done_pulse_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {req_start, req_end};
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      done_pulse_q <= done;
      case (state_q)
        ST_IDLE: begin
          if (claim) begin
            active_start_q <= fifo_q[rd_ptr_q][ENT_W-1:NODE_W];
            active_end_q   <= fifo_q[rd_ptr_q][NODE_W-1:0];
            state_q        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Active fields stay readable after DONE until the next claim.
          if (done) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign status_word = {16'h0000, 8'(count_q), 5'b00000, busy, full, not_empty};

  always_comb begin
    ReadData = '0;
    rd_hit   = hit_start || hit_end || hit_status;
    if (hit_start) begin
      ReadData = 32'(active_start_q);
    end else if (hit_end) begin
      ReadData = 32'(active_end_q);
    end else if (hit_status) begin
      ReadData = status_word;
    end
  end

endmodule

// File: tb/tb_path_request_feeder.sv
// Bench for path_request_feeder: queued requests are mirrored in exp_q and
// popped when the CPU side claims them and reads START/END back.
module tb_path_request_feeder;

  localparam logic [31:0] A_START  = 32'h0200_0000;
  localparam logic [31:0] A_END    = 32'h0200_0004;
  localparam logic [31:0] A_DONE   = 32'h0200_000C;
  localparam logic [31:0] A_STATUS = 32'h0200_0010;
  localparam logic [31:0] A_CLAIM  = 32'h0200_0014;
  localparam logic [31:0] A_UNMAP  = 32'h0200_0020;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_start;
  logic [4:0]  req_end;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        rd_hit;
  logic        busy;
  logic        done_pulse;

  logic [9:0]  exp_q[$];
  int          n_cmp;
  int          n_err;

  path_request_feeder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_start  (req_start),
    .req_end    (req_end),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .rd_hit     (rd_hit),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks (the DUT acts on the falling edge; we drive/sample 1 after it)
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] adr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = adr;
    WriteData = data;
    step();
    MemWrite  = 1'b0;
    DataAdr   = A_UNMAP;
    WriteData = '0;
  endtask

  task automatic bus_read(input logic [31:0] adr, output logic [31:0] data);
    DataAdr = adr;
    #1;
    data = ReadData;
  endtask

  task automatic push_req(input logic [4:0] s, input logic [4:0] e);
    bit ok = 1'b0;
    req_valid = 1'b1;
    req_start = s;
    req_end   = e;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (req_ready) begin
        step();
        exp_q.push_back({s, e});
        ok = 1'b1;
      end else begin
        step();
      end
    end
    req_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL push_accept: request (%0d,%0d) not accepted within 20 cycles", s, e);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want %h", d, 32'h0); end
    n_cmp++; if (rd_hit !== 1'b1) begin n_err++; $display("FAIL reset_status_hit: got %b want 1", rd_hit); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done_pulse !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_pulse); end
    bus_read(A_UNMAP, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_data: got %h want 0", d); end
    n_cmp++; if (rd_hit !== 1'b0) begin n_err++; $display("FAIL unmapped_hit: got %b want 0", rd_hit); end
  endtask

  task automatic test_claim();
    logic [31:0] d;
    logic [9:0]  e;
    push_req(5'd3, 5'd7);
    bus_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h0000_0101) begin n_err++; $display("FAIL claim_pre_status: got %h want %h", d, 32'h101); end
    bus_write(A_CLAIM, 32'd1);
    e = exp_q.pop_front();
    bus_read(A_START, d);
    n_cmp++; if (d !== {27'd0, e[9:5]}) begin n_err++; $display("FAIL claim_start: got %0d want %0d", d, e[9:5]); end
    bus_read(A_END, d);
    n_cmp++; if (d !== {27'd0, e[4:0]}) begin n_err++; $display("FAIL claim_end: got %0d want %0d", d, e[4:0]); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL claim_busy: got %b want 1", busy); end
    bus_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h0000_0004) begin n_err++; $display("FAIL claim_post_status: got %h want %h", d, 32'h4); end
    bus_write(A_DONE, 32'd1);
    n_cmp++; if (done_pulse !== 1'b1) begin n_err++; $display("FAIL claim_done_pulse: got %b want 1", done_pulse); end
    step();
    n_cmp++; if (done_pulse !== 1'b0) begin n_err++; $display("FAIL claim_done_one_cycle: got %b want 0", done_pulse); end
  endtask

  task automatic test_full();
    logic [31:0] d;
    logic [9:0]  e;
    push_req(5'd1, 5'd2);
    push_req(5'd4, 5'd5);
    bus_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h0000_0203) begin n_err++; $display("FAIL full_status: got %h want %h", d, 32'h203); end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", req_ready); end
    req_valid = 1'b1; req_start = 5'd6; req_end = 5'd6;
    step();
    bus_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h0000_0203) begin n_err++; $display("FAIL full_no_push: got %h want %h", d, 32'h203); end
    // Claim on a full FIFO while the third request is still held valid
    bus_write(A_CLAIM, 32'd1);
    e = exp_q.pop_front();
    bus_read(A_START, d);
    n_cmp++; if (d !== {27'd0, e[9:5]}) begin n_err++; $display("FAIL full_claim_start: got %0d want %0d", d, e[9:5]); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after_claim: got %b want 1", req_ready); end
    step();
    exp_q.push_back({5'd6, 5'd6});
    req_valid = 1'b0;
    bus_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h0000_0207) begin n_err++; $display("FAIL full_refill_status: got %h want %h", d, 32'h207); end
  endtask

  task automatic test_done();
    logic [31:0] d;
    logic [9:0]  e;
    bus_write(A_CLAIM, 32'd1);
    bus_read(A_START, d);
    n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL busy_claim_start: got %0d want 1", d); end
    bus_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h0000_0207) begin n_err++; $display("FAIL busy_claim_status: got %h want %h", d, 32'h207); end
    bus_write(A_DONE, 32'd1);
    n_cmp++; if (done_pulse !== 1'b1) begin n_err++; $display("FAIL done_pulse: got %b want 1", done_pulse); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL done_busy: got %b want 0", busy); end
    bus_read(A_START, d);
    n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL done_hold_start: got %0d want 1", d); end
    bus_write(A_DONE, 32'd1);
    n_cmp++; if (done_pulse !== 1'b0) begin n_err++; $display("FAIL done_idle_no_pulse: got %b want 0", done_pulse); end
    bus_write(A_CLAIM, 32'd2);
    bus_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h0000_0203) begin n_err++; $display("FAIL claim_bad_data: got %h want %h", d, 32'h203); end
    // Drain the two queued requests
    for (int k = 0; k < 2; k++) begin
      bus_write(A_CLAIM, 32'd1);
      e = exp_q.pop_front();
      bus_read(A_START, d);
      n_cmp++; if (d !== {27'd0, e[9:5]}) begin n_err++; $display("FAIL drain_start: got %0d want %0d", d, e[9:5]); end
      bus_read(A_END, d);
      n_cmp++; if (d !== {27'd0, e[4:0]}) begin n_err++; $display("FAIL drain_end: got %0d want %0d", d, e[4:0]); end
      bus_write(A_DONE, 32'd1);
    end
    bus_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL drain_status: got %h want 0", d); end
  endtask

  task automatic test_same_edge();
    logic [31:0] d;
    logic [9:0]  e;
    req_valid = 1'b1; req_start = 5'd9; req_end = 5'd10;
    bus_write(A_CLAIM, 32'd1);
    exp_q.push_back({5'd9, 5'd10});
    req_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL same_edge_busy: got %b want 0", busy); end
    bus_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h0000_0101) begin n_err++; $display("FAIL same_edge_status: got %h want %h", d, 32'h101); end
    bus_write(A_CLAIM, 32'd1);
    e = exp_q.pop_front();
    bus_read(A_START, d);
    n_cmp++; if (d !== {27'd0, e[9:5]}) begin n_err++; $display("FAIL same_edge_start: got %0d want %0d", d, e[9:5]); end
    bus_read(A_END, d);
    n_cmp++; if (d !== {27'd0, e[4:0]}) begin n_err++; $display("FAIL same_edge_end: got %0d want %0d", d, e[4:0]); end
    bus_write(A_START, 32'h1F);
    bus_read(A_START, d);
    n_cmp++; if (d !== 32'd9) begin n_err++; $display("FAIL store_start_ignored: got %0d want 9", d); end
    bus_write(A_DONE, 32'd1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [9:0]  e;
    for (int k = 0; k < 6; k++) begin
      push_req(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      bus_write(A_CLAIM, 32'd1);
      e = exp_q.pop_front();
      bus_read(A_START, d);
      n_cmp++; if (d !== {27'd0, e[9:5]}) begin n_err++; $display("FAIL b2b_start: got %0d want %0d", d, e[9:5]); end
      bus_read(A_END, d);
      n_cmp++; if (d !== {27'd0, e[4:0]}) begin n_err++; $display("FAIL b2b_end: got %0d want %0d", d, e[4:0]); end
      bus_write(A_DONE, 32'd1);
      n_cmp++; if (done_pulse !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", done_pulse); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    push_req(5'd11, 5'd12);
    push_req(5'd13, 5'd14);
    bus_write(A_CLAIM, 32'd1);
    void'(exp_q.pop_front());
    push_req(5'd15, 5'd16);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_ready: got %b want 1", req_ready); end
    bus_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_reset_status: got %h want 0", d); end
    step();
    reset_n = 1'b1;
    step();
    bus_read(A_STATUS, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL post_reset_status: got %h want 0", d); end
    bus_read(A_START, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL post_reset_start: got %0d want 0", d); end
    bus_read(A_END, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL post_reset_end: got %0d want 0", d); end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_start = '0;
    req_end   = '0;
    MemWrite  = 1'b0;
    DataAdr   = A_UNMAP;
    WriteData = '0;
    step();
    step();
    reset_n = 1'b1;
    step();

    test_reset();
    test_claim();
    test_full();
    test_done();
    test_same_edge();
    test_back_to_back();
    test_reset_mid();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
